uart_cfg: RTL and testbench
===========================

Name: uart_cfg

Overview:
- Full-duplex UART with a runtime-programmable baud divisor, runtime parity mode, and parametrised data width, stop length and FIFO depth.
- Sticky receive error flags: parity, framing and overrun.
- Successor to the fixed-configuration UART top; self-contained, with its own tick generator and first-word-fall-through (FWFT) RX/TX FIFOs.
- Sits between a host bus (byte read/write strobes) and the serial pins.

Parameters:
- DBIT, 8: data bits per frame, 5..9, LSB first.
- SB_TICK, 16: stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- DVSR_BIT, 11: width of the dvsr port.
- FIFO_W, 4: address width of each FIFO; depth is 2^FIFO_W words.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- dvsr  in  DVSR_BIT  baud divisor; one oversample tick every dvsr+1 clk cycles.
- par_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- wr_uart  in  1  push w_data into the TX FIFO.
- w_data  in  DBIT  transmit word.
- rd_uart  in  1  pop the RX FIFO head.
- rx  in  1  serial input (already synchronised externally).
- err_clr  in  1  clear all sticky error flags.
- tx  out  1  serial output.
- tx_full  out  1  TX FIFO full.
- rx_empty  out  1  RX FIFO empty.
- r_data  out  DBIT  RX FIFO head (FWFT).
- par_err  out  1  sticky parity error.
- frm_err  out  1  sticky framing error.
- ovr_err  out  1  sticky overrun.

Behaviour:
- Reset values:
  - tx=1, tx_full=0, rx_empty=1, r_data=0.
  - All error flags 0; both FSMs in IDLE; tick counter 0; FIFO pointers 0.
  - Reset is asynchronous and may assert mid-frame: all state aborts, no partial word is pushed, and tx returns to 1 immediately.
- Tick generator:
  - Counter runs 0..dvsr, and tick pulses for one clk when count==dvsr.
  - A dvsr change takes effect at the next wrap.
  - dvsr=0 gives a tick every cycle.
- RX FSM (states IDLE, START, DATA, PARITY, STOP):
  - IDLE: rx==0 -> START, tick count n=0.
  - START: on the 8th tick (n==7), if rx==0 -> DATA with n=0, else -> IDLE (glitch rejected).
  - DATA: sample rx every 16th tick and shift it in from the MSB side; after DBIT samples -> PARITY if par_mode is even/odd, else STOP.
  - PARITY: sample at the 16th tick. Mismatch sets par_err; the expected value is XOR of the data for even parity and its inverse for odd.
  - STOP: sample at tick SB_TICK. rx==0 sets frm_err. Then push the word and -> IDLE.
  - Words with a parity or framing error are still pushed.
- RX push while the RX FIFO is full:
  - Without a same-cycle rd_uart, the word is dropped and ovr_err is set.
  - With a same-cycle rd_uart, the pop and the push both take effect and there is no overrun.
- TX FSM (states IDLE, START, DATA, PARITY, STOP):
  - In IDLE with the TX FIFO non-empty: latch the head, pop it the same cycle, then -> START.
  - START drives 0 for 16 ticks.
  - DATA drives DBIT bits LSB first, 16 ticks each.
  - PARITY (if enabled) drives 1 bit for 16 ticks.
  - STOP drives 1 for SB_TICK ticks, then -> IDLE.
  - A back-to-back frame starts 1 clk after STOP ends.
  - par_mode is sampled at frame start for both TX and RX and held for the whole frame.
- FIFOs:
  - FWFT: r_data is valid whenever rx_empty==0.
  - rd_uart on an empty FIFO is ignored.
  - wr_uart on a full FIFO is ignored; the data is lost and no flag is raised.
  - Simultaneous read and write on a non-empty, non-full FIFO keeps the count unchanged.
  - Pointers wrap modulo 2^FIFO_W.
  - tx_full and rx_empty are registered status, updated in the cycle after the causing strobe.
- Error flags:
  - err_clr clears all three flags on the next edge.
  - If a new error event occurs in the same cycle as err_clr, set wins.

Test Plan:
- Loopback (tx tied to rx), dvsr=3, par_mode=00, write 0xA5 -> rx_empty falls after one frame; r_data=0xA5; no error flags.
- par_mode=01, write 0x07 -> tx parity bit=1. Receiving 0x07 with parity bit 0 -> par_err=1 and r_data=0x07; err_clr -> par_err=0.
- Drive rx low for 5 ticks then high -> no word pushed, rx_empty stays 1.
- Frame with stop bit forced 0 -> frm_err=1, word still pushed.
- Receive 2^FIFO_W+1 frames without reading -> ovr_err=1, the FIFO holds the first 16 words, the 17th is dropped. Repeat with rd_uart asserted in the push cycle of the 17th -> no overrun.
- Write 3 words back-to-back, then assert reset low mid-second frame -> tx=1 immediately; after release tx stays 1 and tx_full=0 with the FIFO empty.

Source files
------------

// File: rtl/uart_cfg.sv
// uart_cfg: full-duplex UART with runtime baud divisor and parity mode, sticky RX errors.
// Tick generator, RX/TX FSMs and two first-word-fall-through FIFOs in one file.
module uart_cfg_fifo #(
    parameter int W = 8,
    parameter int B = 4
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_rd,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    logic [W-1:0] r_mem [0:2**B-1];
    logic [B-1:0] r_wp, r_rp, w_wp1, w_rp1;
    logic         r_full, r_empty, w_wr, w_rd;

    assign w_rd    = i_rd & ~r_empty;
    assign w_wr    = i_wr & (~r_full | w_rd);
    assign w_wp1   = r_wp + 1'b1;
    assign w_rp1   = r_rp + 1'b1;
    assign o_rdata = r_empty ? '0 : r_mem[r_rp];
    assign o_full  = r_full;
    assign o_empty = r_empty;

    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wp] <= i_wdata;

    always_ff @(posedge clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr) r_wp <= w_wp1;
            if (w_rd) r_rp <= w_rp1;
            if (w_wr && !w_rd) begin
                r_empty <= 1'b0;
                r_full  <= w_wp1 == r_rp;
            end else if (w_rd && !w_wr) begin
                r_full  <= 1'b0;
                r_empty <= w_rp1 == r_wp;
            end
        end
endmodule

module uart_cfg #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR_BIT = 11,
    parameter int FIFO_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic [1:0]          par_mode,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    input  logic                rd_uart,
    input  logic                rx,
    input  logic                err_clr,
    output logic                tx,
    output logic                tx_full,
    output logic                rx_empty,
    output logic [DBIT-1:0]     r_data,
    output logic                par_err,
    output logic                frm_err,
    output logic                ovr_err
);
    localparam int NW = 6;
    localparam int BW = 4;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // divisor is latched at each wrap so a change never truncates a period
    logic [DVSR_BIT-1:0] r_tcnt, r_dv;
    logic                w_tick;
    assign w_tick = r_tcnt == r_dv;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_tcnt <= '0;
            r_dv   <= '0;
        end else if (w_tick) begin
            r_tcnt <= '0;
            r_dv   <= dvsr;
        end else r_tcnt <= r_tcnt + 1'b1;

    state_t          r_rs, w_rs_nx;
    logic [NW-1:0]   r_rn, w_rn_nx;
    logic [BW-1:0]   r_rbc, w_rbc_nx;
    logic [DBIT-1:0] r_rb, w_rb_nx;
    logic            r_rpen, w_rpen_nx, r_rodd, w_rodd_nx;
    logic            w_rx_push, w_par_ev, w_frm_ev, w_ovr_ev, w_rx_full;

    always_comb begin
        w_rs_nx   = r_rs;
        w_rn_nx   = r_rn;
        w_rbc_nx  = r_rbc;
        w_rb_nx   = r_rb;
        w_rpen_nx = r_rpen;
        w_rodd_nx = r_rodd;
        w_rx_push = 1'b0;
        w_par_ev  = 1'b0;
        w_frm_ev  = 1'b0;
        case (r_rs)
            IDLE: if (!rx) begin
                w_rs_nx   = START;
                w_rn_nx   = '0;
                w_rpen_nx = par_mode == 2'b01 || par_mode == 2'b10;
                w_rodd_nx = par_mode == 2'b10;
            end
            START: if (w_tick) begin
                if (r_rn == NW'(7)) begin
                    w_rs_nx  = rx ? IDLE : DATA;
                    w_rn_nx  = '0;
                    w_rbc_nx = '0;
                end else w_rn_nx = r_rn + 1'b1;
            end
            DATA: if (w_tick) begin
                if (r_rn == NW'(15)) begin
                    w_rn_nx  = '0;
                    w_rb_nx  = {rx, r_rb[DBIT-1:1]};
                    w_rbc_nx = r_rbc + 1'b1;
                    if (r_rbc == BW'(DBIT-1)) w_rs_nx = r_rpen ? PARITY : STOP;
                end else w_rn_nx = r_rn + 1'b1;
            end
            PARITY: if (w_tick) begin
                if (r_rn == NW'(15)) begin
                    w_rn_nx  = '0;
                    w_par_ev = rx != ((^r_rb) ^ r_rodd);
                    w_rs_nx  = STOP;
                end else w_rn_nx = r_rn + 1'b1;
            end
            STOP: if (w_tick) begin
                if (r_rn == NW'(SB_TICK-1)) begin
                    w_rx_push = 1'b1;
                    w_frm_ev  = ~rx;
                    w_rs_nx   = IDLE;
                end else w_rn_nx = r_rn + 1'b1;
            end
            default: w_rs_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_rs   <= IDLE;
            r_rn   <= '0;
            r_rbc  <= '0;
            r_rb   <= '0;
            r_rpen <= 1'b0;
            r_rodd <= 1'b0;
        end else begin
            r_rs   <= w_rs_nx;
            r_rn   <= w_rn_nx;
            r_rbc  <= w_rbc_nx;
            r_rb   <= w_rb_nx;
            r_rpen <= w_rpen_nx;
            r_rodd <= w_rodd_nx;
        end

    state_t          r_ts, w_ts_nx;
    logic [NW-1:0]   r_tn, w_tn_nx;
    logic [BW-1:0]   r_tbc, w_tbc_nx;
    logic [DBIT-1:0] r_tb, w_tb_nx, w_tx_head;
    logic            r_tpen, w_tpen_nx, r_tpar, w_tpar_nx, w_tx_pop, w_tx_empty;

    always_comb begin
        w_ts_nx   = r_ts;
        w_tn_nx   = r_tn;
        w_tbc_nx  = r_tbc;
        w_tb_nx   = r_tb;
        w_tpen_nx = r_tpen;
        w_tpar_nx = r_tpar;
        w_tx_pop  = 1'b0;
        case (r_ts)
            IDLE: if (!w_tx_empty) begin
                w_ts_nx   = START;
                w_tn_nx   = '0;
                w_tb_nx   = w_tx_head;
                w_tpen_nx = par_mode == 2'b01 || par_mode == 2'b10;
                w_tpar_nx = (^w_tx_head) ^ (par_mode == 2'b10);
                w_tx_pop  = 1'b1;
            end
            START: if (w_tick) begin
                if (r_tn == NW'(15)) begin
                    w_ts_nx  = DATA;
                    w_tn_nx  = '0;
                    w_tbc_nx = '0;
                end else w_tn_nx = r_tn + 1'b1;
            end
            DATA: if (w_tick) begin
                if (r_tn == NW'(15)) begin
                    w_tn_nx  = '0;
                    w_tb_nx  = r_tb >> 1;
                    w_tbc_nx = r_tbc + 1'b1;
                    if (r_tbc == BW'(DBIT-1)) w_ts_nx = r_tpen ? PARITY : STOP;
                end else w_tn_nx = r_tn + 1'b1;
            end
            PARITY: if (w_tick) begin
                if (r_tn == NW'(15)) begin
                    w_tn_nx = '0;
                    w_ts_nx = STOP;
                end else w_tn_nx = r_tn + 1'b1;
            end
            STOP: if (w_tick) begin
                if (r_tn == NW'(SB_TICK-1)) w_ts_nx = IDLE;
                else w_tn_nx = r_tn + 1'b1;
            end
            default: w_ts_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_ts   <= IDLE;
            r_tn   <= '0;
            r_tbc  <= '0;
            r_tb   <= '0;
            r_tpen <= 1'b0;
            r_tpar <= 1'b0;
        end else begin
            r_ts   <= w_ts_nx;
            r_tn   <= w_tn_nx;
            r_tbc  <= w_tbc_nx;
            r_tb   <= w_tb_nx;
            r_tpen <= w_tpen_nx;
            r_tpar <= w_tpar_nx;
        end

    // decoded straight from state so an async reset forces the line idle at once
    assign tx = r_ts == START ? 1'b0 : r_ts == DATA ? r_tb[0] : r_ts == PARITY ? r_tpar : 1'b1;

    uart_cfg_fifo #(.W(DBIT), .B(FIFO_W)) u_rx_fifo (
        .clk(clk), .i_rst_n(reset), .i_wr(w_rx_push), .i_wdata(r_rb), .i_rd(rd_uart),
        .o_rdata(r_data), .o_full(w_rx_full), .o_empty(rx_empty)
    );

    uart_cfg_fifo #(.W(DBIT), .B(FIFO_W)) u_tx_fifo (
        .clk(clk), .i_rst_n(reset), .i_wr(wr_uart), .i_wdata(w_data), .i_rd(w_tx_pop),
        .o_rdata(w_tx_head), .o_full(tx_full), .o_empty(w_tx_empty)
    );

    assign w_ovr_ev = w_rx_push & w_rx_full & ~rd_uart;

    logic r_par_err, r_frm_err, r_ovr_err;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovr_err <= 1'b0;
        end else begin
            r_par_err <= w_par_ev | (r_par_err & ~err_clr);
            r_frm_err <= w_frm_ev | (r_frm_err & ~err_clr);
            r_ovr_err <= w_ovr_ev | (r_ovr_err & ~err_clr);
        end

    assign par_err = r_par_err;
    assign frm_err = r_frm_err;
    assign ovr_err = r_ovr_err;
endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: scoreboard bench for uart_cfg; expected RX words are queued by the
// stimulus and a monitor pops/compares whenever the RX FIFO presents a word.
module tb_uart_cfg;
    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] dvsr;
    logic [1:0]  par_mode;
    logic        wr_uart, rd_uart, rx, err_clr;
    logic [7:0]  w_data, r_data;
    logic        tx, tx_full, rx_empty, par_err, frm_err, ovr_err;
    logic        lb, rx_drv, mon_rd, tb_rd, auto_rd;
    logic [7:0]  sb[$];
    int          pass_cnt = 0, total_cnt = 0;

    always #5 clk = ~clk;
    assign rx      = lb ? tx : rx_drv;
    assign rd_uart = mon_rd | tb_rd;

    uart_cfg dut (
        .clk(clk), .reset(reset), .dvsr(dvsr), .par_mode(par_mode), .wr_uart(wr_uart),
        .w_data(w_data), .rd_uart(rd_uart), .rx(rx), .err_clr(err_clr), .tx(tx),
        .tx_full(tx_full), .rx_empty(rx_empty), .r_data(r_data), .par_err(par_err),
        .frm_err(frm_err), .ovr_err(ovr_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    initial begin
        mon_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_rd && reset && !rx_empty) begin
                if (sb.size() == 0) chk("rx_word_unexpected", {24'd0, r_data}, 32'hFFFF_FFFF);
                else chk("rx_word", r_data, sb.pop_front());
                mon_rd = 1'b1;
            end else mon_rd = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic write_word(input logic [7:0] d);
        @(negedge clk);
        wr_uart = 1'b1;
        w_data  = d;
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int i = 0;
        while (sb.size() != 0 && i < max) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic wait_fall(input int max);
        int i = 0;
        while (tx !== 1'b0 && i < max) begin
            @(negedge clk);
            i++;
        end
        chk("tx_start_seen", i < max, 1);
    endtask

    // bl = clocks per bit; bad_stop holds the stop bit low only past its sampling point
    task automatic drive_frame(input logic [7:0] d, input bit pe, input bit pb,
                               input bit stop_ok, input int bl);
        @(posedge clk);
        #1 rx_drv = 1'b0;
        repeat (bl) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1 rx_drv = d[k];
            repeat (bl) @(posedge clk);
        end
        if (pe) begin
            #1 rx_drv = pb;
            repeat (bl) @(posedge clk);
        end
        #1;
        if (stop_ok) begin
            rx_drv = 1'b1;
            repeat (bl) @(posedge clk);
        end else begin
            rx_drv = 1'b0;
            repeat (bl * 5 / 8) @(posedge clk);
            #1 rx_drv = 1'b1;
            repeat (bl) @(posedge clk);
        end
        #1 rx_drv = 1'b1;
    endtask

    initial begin
        reset = 1'b0; dvsr = 11'd3; par_mode = 2'b00; wr_uart = 1'b0; w_data = '0;
        tb_rd = 1'b0; rx_drv = 1'b1; err_clr = 1'b0; lb = 1'b1; auto_rd = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_tx_full", tx_full, 0);
        chk("reset_rx_empty", rx_empty, 1);
        chk("reset_r_data", r_data, 0);
        chk("reset_par_err", par_err, 0);
        chk("reset_frm_err", frm_err, 0);
        chk("reset_ovr_err", ovr_err, 0);
        reset = 1'b1;
        auto_rd = 1'b1;

        sb.push_back(8'hA5);
        write_word(8'hA5);
        wait_drain(3000);
        chk("loop_a5_errs", {par_err, frm_err, ovr_err}, 0);

        par_mode = 2'b01;
        sb.push_back(8'h07);
        write_word(8'h07);
        wait_fall(100);
        repeat (288) @(negedge clk);
        chk("tx_data_bit3", tx, 0);
        repeat (320) @(negedge clk);
        chk("tx_even_parity_bit", tx, 1);
        wait_drain(2000);
        chk("loop_even_par_err", par_err, 0);

        lb = 1'b0;
        sb.push_back(8'h07);
        drive_frame(8'h07, 1'b1, 1'b0, 1'b1, 64);
        wait_drain(500);
        chk("bad_parity_par_err", par_err, 1);
        pulse_clr();
        chk("par_err_cleared", par_err, 0);

        par_mode = 2'b00;
        @(posedge clk);
        #1 rx_drv = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_rx_empty", rx_empty, 1);
        chk("glitch_frm_err", frm_err, 0);

        sb.push_back(8'h3C);
        drive_frame(8'h3C, 1'b0, 1'b0, 1'b0, 64);
        wait_drain(500);
        chk("bad_stop_frm_err", frm_err, 1);
        pulse_clr();
        chk("frm_err_cleared", frm_err, 0);

        dvsr = 11'd0;
        repeat (10) @(negedge clk);
        auto_rd = 1'b0;
        for (int i = 0; i < 17; i++) drive_frame(8'h40 + 8'(i), 1'b0, 1'b0, 1'b1, 16);
        repeat (5) @(negedge clk);
        chk("overrun_ovr_err", ovr_err, 1);
        chk("overrun_head", r_data, 8'h40);
        for (int i = 0; i < 16; i++) sb.push_back(8'h40 + 8'(i));
        auto_rd = 1'b1;
        wait_drain(200);
        chk("overrun_drained_empty", rx_empty, 1);
        pulse_clr();
        chk("ovr_err_cleared", ovr_err, 0);

        auto_rd = 1'b0;
        for (int i = 0; i < 16; i++) drive_frame(8'h80 + 8'(i), 1'b0, 1'b0, 1'b1, 16);
        fork
            drive_frame(8'h90, 1'b0, 1'b0, 1'b1, 16);
            begin
                @(posedge clk);
                repeat (152) @(posedge clk);
                #1 chk("full_head_before_pop", r_data, 8'h80);
                tb_rd = 1'b1;
                @(posedge clk);
                #1 tb_rd = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        chk("pop_push_no_ovr", ovr_err, 0);
        for (int i = 1; i < 17; i++) sb.push_back(8'h80 + 8'(i));
        auto_rd = 1'b1;
        wait_drain(200);
        chk("pop_push_drained_empty", rx_empty, 1);

        dvsr = 11'd3;
        lb = 1'b1;
        repeat (10) @(negedge clk);
        sb.push_back(8'h5A);
        @(negedge clk);
        wr_uart = 1'b1;
        w_data  = 8'h5A;
        @(negedge clk);
        w_data  = 8'h00;
        @(negedge clk);
        w_data  = 8'hFF;
        @(negedge clk);
        wr_uart = 1'b0;
        wait_fall(100);
        repeat (960) @(negedge clk);
        chk("tx_low_mid_second_frame", tx, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("tx_high_on_async_reset", tx, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        chk("post_reset_tx", tx, 1);
        chk("post_reset_tx_full", tx_full, 0);
        chk("post_reset_rx_empty", rx_empty, 1);
        chk("post_reset_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
